// File: rtl/vx_ram_pkg.sv
// Shared RAM-wrapper definitions: init/run state type and the byte-enable
// merge helper used by RAM wrappers that forward in-flight write data.
package vx_ram_pkg;

  typedef enum logic {
    INIT,
    RUN
  } ram_state_e;

  // Widest word / enable vector the merge helper can handle; callers
  // zero-extend into these and truncate the result back to their own width.
  localparam int MERGE_MAXW  = 512;
  localparam int MERGE_MAXEN = 64;

  typedef logic [$clog2(MERGE_MAXW)-1:0]  merge_bit_idx_t;
  typedef logic [$clog2(MERGE_MAXEN)-1:0] merge_en_idx_t;

  // Each bit of the result comes from new_data when the enable of the lane
  // that bit belongs to is set, otherwise from old_data.
  function automatic logic [MERGE_MAXW-1:0] byteen_merge(
    input logic [MERGE_MAXW-1:0]  old_data,
    input logic [MERGE_MAXW-1:0]  new_data,
    input logic [MERGE_MAXEN-1:0] byteen,
    input int                     lane_bits
  );
    logic [MERGE_MAXW-1:0] merged;
    merge_bit_idx_t        bit_idx;
    merge_en_idx_t         en_idx;
    merged = old_data;
    for (int i = 0; i < MERGE_MAXW; i++) begin
      bit_idx = merge_bit_idx_t'(i);
      en_idx  = merge_en_idx_t'(i / lane_bits);
      if (byteen[en_idx]) begin
        merged[bit_idx] = new_data[bit_idx];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/vx_ram_init_ctrl.sv
// Post-reset fill sequencer: walks every entry once, writing INIT_VALUE,
// then raises init_done and stays there until the next reset.
module vx_ram_init_ctrl
  import vx_ram_pkg::*;
#(
  parameter int              SIZE       = 64,
  parameter int              ADDRW      = $clog2(SIZE),
  parameter int              DATAW      = 32,
  parameter logic [DATAW-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             init_done,
  output logic             fill_en,
  output logic [ADDRW-1:0] fill_addr,
  output logic [DATAW-1:0] fill_data
);

  // One extra bit so the counter can reach SIZE without wrapping.
  localparam int              CNTW = $clog2(SIZE + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(SIZE - 1);

  ram_state_e      state;
  ram_state_e      next_state;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] next_count;

  // State and fill counter registers; reset restarts the fill at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Fill one entry per cycle in INIT, leave after the last entry is written.
  always_comb begin
    next_state = state;
    next_count = count;
    fill_en    = 1'b0;
    init_done  = 1'b0;
    case (state)
      INIT: begin
        fill_en    = 1'b1;
        next_count = count + CNTW'(1);
        if (count == LAST) begin
          next_state = RUN;
        end
      end
      RUN: begin
        init_done = 1'b1;
      end
      default: begin
        next_state = INIT;
      end
    endcase
  end

  assign fill_addr = ADDRW'(count);
  assign fill_data = INIT_VALUE;

endmodule

// File: rtl/vx_init_dp_ram.sv
// One-write/one-read RAM with hardware fill after reset, lane write enables
// and a valid/ready read pipeline of latency 1 (OUT_REG=0) or 2 (OUT_REG=1).
// Define VX_RAM_BYPASS_EN to forward same-cycle write data to a colliding
// read; otherwise a collision returns the pre-write contents.
module vx_init_dp_ram
  import vx_ram_pkg::*;
#(
  parameter int               DATAW      = 32,
  parameter int               SIZE       = 64,
  parameter int               BYTEENW    = 1,
  parameter int               OUT_REG    = 0,
  parameter logic [DATAW-1:0] INIT_VALUE = '0,
  parameter int               ADDRW      = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               init_done,
  input  logic               wr_en,
  input  logic [ADDRW-1:0]   wr_addr,
  input  logic [BYTEENW-1:0] wr_byteen,
  input  logic [DATAW-1:0]   wr_data,
  input  logic               rd_req_valid,
  input  logic [ADDRW-1:0]   rd_req_addr,
  output logic               rd_req_ready,
  output logic               rd_rsp_valid,
  output logic [DATAW-1:0]   rd_rsp_data,
  input  logic               rd_rsp_ready
);

  localparam int LANEW = DATAW / BYTEENW;

  logic             fill_en;
  logic [ADDRW-1:0] fill_addr;
  logic [DATAW-1:0] fill_data;

  vx_ram_init_ctrl #(
    .SIZE       (SIZE),
    .ADDRW      (ADDRW),
    .DATAW      (DATAW),
    .INIT_VALUE (INIT_VALUE)
  ) init_ctrl (
    .clk       (clk),
    .reset     (reset),
    .init_done (init_done),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_data (fill_data)
  );

  logic [DATAW-1:0] mem [SIZE];
  logic             stall;
  logic             rd_accept;
  logic             user_we;
  logic [DATAW-1:0] rd_mem_q;
  logic             s1_valid;
  logic [DATAW-1:0] s1_data;

  // A response the consumer is not taking freezes every pipeline stage.
  assign stall        = rd_rsp_valid && !rd_rsp_ready;
  assign rd_req_ready = init_done && !stall;
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign user_we      = init_done && wr_en;

  // Single write port: the fill sequencer owns it until init_done.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      mem[fill_addr] <= fill_data;
    end else if (user_we) begin
      for (int i = 0; i < BYTEENW; i++) begin
        if (wr_byteen[i]) begin
          mem[wr_addr][i*LANEW +: LANEW] <= wr_data[i*LANEW +: LANEW];
        end
      end
    end
  end

  // Registered array read, captured only on acceptance so stalls hold it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_mem_q <= '0;
    end else if (rd_accept) begin
      rd_mem_q <= mem[rd_req_addr];
    end
  end

  // Stage-1 valid: advances whenever the pipeline is not frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= rd_accept;
    end
  end

`ifdef VX_RAM_BYPASS_EN
  logic               fwd_hit;
  logic [DATAW-1:0]   fwd_data;
  logic [BYTEENW-1:0] fwd_byteen;

  // Remember a same-cycle write to the accepted address for merging.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit    <= 1'b0;
      fwd_data   <= '0;
      fwd_byteen <= '0;
    end else if (rd_accept) begin
      fwd_hit    <= user_we && (wr_addr == rd_req_addr);
      fwd_data   <= wr_data;
      fwd_byteen <= wr_byteen;
    end
  end

  assign s1_data = fwd_hit
                 ? DATAW'(byteen_merge(MERGE_MAXW'(rd_mem_q), MERGE_MAXW'(fwd_data),
                                       MERGE_MAXEN'(fwd_byteen), LANEW))
                 : rd_mem_q;
`else
  assign s1_data = rd_mem_q;
`endif

  if (OUT_REG != 0) begin : g_out_reg
    logic             s2_valid;
    logic [DATAW-1:0] s2_data;

    // Extra output stage, frozen together with stage 1.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else if (!stall) begin
        s2_valid <= s1_valid;
        s2_data  <= s1_data;
      end
    end

    assign rd_rsp_valid = s2_valid;
    assign rd_rsp_data  = s2_data;
  end else begin : g_no_out_reg
    assign rd_rsp_valid = s1_valid;
    assign rd_rsp_data  = s1_data;
  end

endmodule

// File: tb/tb_vx_init_dp_ram.sv
// Bench for vx_init_dp_ram: one instance per read latency, driven by the same
// stimulus, each with its own in-order response scoreboard against a plain
// array model of the memory. Honours VX_RAM_BYPASS_EN like the design.
module tb_vx_init_dp_ram;

  localparam int               DATAW      = 32;
  localparam int               SIZE       = 12;
  localparam int               BYTEENW    = 4;
  localparam int               ADDRW      = $clog2(SIZE);
  localparam logic [DATAW-1:0] INIT_VALUE = 32'hA5A5A5A5;
`ifdef VX_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wr_en = 1'b0;
  logic [ADDRW-1:0]   wr_addr = '0;
  logic [BYTEENW-1:0] wr_byteen = '0;
  logic [DATAW-1:0]   wr_data = '0;
  logic               rd_req_valid = 1'b0;
  logic [ADDRW-1:0]   rd_req_addr = '0;
  logic               rd_rsp_ready = 1'b1;

  logic             init_done_a, rd_req_ready_a, rd_rsp_valid_a;
  logic [DATAW-1:0] rd_rsp_data_a;
  logic             init_done_b, rd_req_ready_b, rd_rsp_valid_b;
  logic [DATAW-1:0] rd_rsp_data_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  vx_init_dp_ram #(
    .DATAW(DATAW), .SIZE(SIZE), .BYTEENW(BYTEENW), .OUT_REG(0), .INIT_VALUE(INIT_VALUE)
  ) dut_a (
    .clk(clk), .reset(reset), .init_done(init_done_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_byteen(wr_byteen), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready_a),
    .rd_rsp_valid(rd_rsp_valid_a), .rd_rsp_data(rd_rsp_data_a), .rd_rsp_ready(rd_rsp_ready)
  );

  vx_init_dp_ram #(
    .DATAW(DATAW), .SIZE(SIZE), .BYTEENW(BYTEENW), .OUT_REG(1), .INIT_VALUE(INIT_VALUE)
  ) dut_b (
    .clk(clk), .reset(reset), .init_done(init_done_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_byteen(wr_byteen), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready_b),
    .rd_rsp_valid(rd_rsp_valid_b), .rd_rsp_data(rd_rsp_data_b), .rd_rsp_ready(rd_rsp_ready)
  );

  // Reference model: word array, fill-done flag and expected response queues.
  logic [DATAW-1:0] ref_mem [SIZE];
  logic [DATAW-1:0] exp_q_a [$];
  logic [DATAW-1:0] exp_q_b [$];
  int               fill_edges = 0;

  function automatic logic [DATAW-1:0] merge_word(input logic [DATAW-1:0] old_w,
                                                  input logic [DATAW-1:0] new_w,
                                                  input logic [BYTEENW-1:0] en);
    logic [DATAW-1:0] res;
    res = old_w;
    for (int b = 0; b < BYTEENW; b++) begin
      if (en[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Scoreboard: sees pre-edge values at each rising edge.
  always @(posedge clk) begin
    logic             running;
    logic [DATAW-1:0] rd_exp;
    if (reset) begin
      fill_edges = 0;
      exp_q_a.delete();
      exp_q_b.delete();
      for (int i = 0; i < SIZE; i++) ref_mem[i] = INIT_VALUE;
    end else begin
      running = (fill_edges >= SIZE);
      if (fill_edges <= SIZE) fill_edges++;
      tests_run++;
      assert ({init_done_a, init_done_b} === {running, running}) else begin
        tests_failed++;
        $error("[TB] FAIL init_done: observed a=%b b=%b expected %b", init_done_a, init_done_b, running);
      end
      if (!running) begin
        tests_run++;
        assert ({rd_req_ready_a, rd_req_ready_b} === 2'b00) else begin
          tests_failed++;
          $error("[TB] FAIL ready_in_init: observed a=%b b=%b expected 0", rd_req_ready_a, rd_req_ready_b);
        end
      end
      if (rd_rsp_ready && rd_rsp_valid_a === 1'b1) begin
        tests_run++;
        if (exp_q_a.size() == 0) begin
          tests_failed++;
          $error("[TB] FAIL rsp_a_extra: observed %h expected no response", rd_rsp_data_a);
        end else begin
          rd_exp = exp_q_a.pop_front();
          assert (rd_rsp_data_a === rd_exp) else begin
            tests_failed++;
            $error("[TB] FAIL rsp_a_data: observed %h expected %h", rd_rsp_data_a, rd_exp);
          end
        end
      end
      if (rd_rsp_ready && rd_rsp_valid_b === 1'b1) begin
        tests_run++;
        if (exp_q_b.size() == 0) begin
          tests_failed++;
          $error("[TB] FAIL rsp_b_extra: observed %h expected no response", rd_rsp_data_b);
        end else begin
          rd_exp = exp_q_b.pop_front();
          assert (rd_rsp_data_b === rd_exp) else begin
            tests_failed++;
            $error("[TB] FAIL rsp_b_data: observed %h expected %h", rd_rsp_data_b, rd_exp);
          end
        end
      end
      if (rd_req_valid) begin
        rd_exp = ref_mem[rd_req_addr];
        if (BYPASS && running && wr_en && wr_addr == rd_req_addr) begin
          rd_exp = merge_word(rd_exp, wr_data, wr_byteen);
        end
        if (rd_req_ready_a) exp_q_a.push_back(rd_exp);
        if (rd_req_ready_b) exp_q_b.push_back(rd_exp);
      end
      if (running && wr_en) begin
        ref_mem[wr_addr] = merge_word(ref_mem[wr_addr], wr_data, wr_byteen);
      end
    end
  end

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic [DATAW-1:0] observed,
                              input logic [DATAW-1:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic we, input int waddr, input int wbe,
                                input logic [DATAW-1:0] wdata, input logic rv, input int raddr);
    wr_en        = we;
    wr_addr      = ADDRW'(waddr);
    wr_byteen    = BYTEENW'(wbe);
    wr_data      = wdata;
    rd_req_valid = rv;
    rd_req_addr  = ADDRW'(raddr);
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 0, 0, '0, 1'b0, 0);
  endtask

  // Releases reset and hammers writes/reads during the fill window.
  task automatic fill_and_check(input string tag);
    reset = 1'b0;
    apply_stimulus(1'b1, 0, 'hF, 32'hFFFFFFFF, 1'b1, 0);
    for (int j = 1; j <= SIZE; j++) begin
      @(negedge clk);
      if (j == SIZE - 1) begin
        check_bit({tag, "_done_early_a"}, init_done_a, 1'b0);
        check_bit({tag, "_done_early_b"}, init_done_b, 1'b0);
      end
      apply_stimulus(1'b1, j % SIZE, 'hF, 32'hFFFFFFFF, 1'b1, j % SIZE);
    end
    check_bit({tag, "_done_a"}, init_done_a, 1'b1);
    check_bit({tag, "_done_b"}, init_done_b, 1'b1);
    apply_idle();
  endtask

  task automatic read_all();
    for (int i = 0; i < SIZE; i++) begin
      apply_stimulus(1'b0, 0, 0, '0, 1'b1, i);
      @(negedge clk);
    end
    apply_idle();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    apply_idle();
    rd_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("rst_done_a", init_done_a, 1'b0);
    check_bit("rst_ready_a", rd_req_ready_a, 1'b0);
    check_bit("rst_valid_a", rd_rsp_valid_a, 1'b0);
    check_output("rst_data_a", rd_rsp_data_a, '0);
    check_bit("rst_valid_b", rd_rsp_valid_b, 1'b0);
    check_output("rst_data_b", rd_rsp_data_b, '0);

    fill_and_check("fill1");
    read_all();

    apply_stimulus(1'b0, 0, 0, '0, 1'b1, 4);
    @(negedge clk);
    check_bit("lat_valid_a", rd_rsp_valid_a, 1'b1);
    check_output("lat_data_a", rd_rsp_data_a, INIT_VALUE);
    check_bit("lat_valid_b_early", rd_rsp_valid_b, 1'b0);
    apply_idle();
    @(negedge clk);
    check_bit("lat_valid_a_drop", rd_rsp_valid_a, 1'b0);
    check_bit("lat_valid_b", rd_rsp_valid_b, 1'b1);
    check_output("lat_data_b", rd_rsp_data_b, INIT_VALUE);

    apply_stimulus(1'b1, 3, 'hF, 32'h0, 1'b0, 0);
    @(negedge clk);
    apply_stimulus(1'b1, 3, 'h5, 32'h11223344, 1'b0, 0);
    @(negedge clk);
    apply_stimulus(1'b0, 0, 0, '0, 1'b1, 3);
    @(negedge clk);
    check_output("bytewr_a", rd_rsp_data_a, 32'h00220044);
    apply_stimulus(1'b1, 3, 'h0, 32'hFFFFFFFF, 1'b0, 0);
    @(negedge clk);
    check_output("bytewr_b", rd_rsp_data_b, 32'h00220044);
    apply_stimulus(1'b0, 0, 0, '0, 1'b1, 3);
    @(negedge clk);
    check_output("zero_byteen_a", rd_rsp_data_a, 32'h00220044);

    apply_stimulus(1'b1, 7, 'hF, 32'h0, 1'b0, 0);
    @(negedge clk);
    apply_stimulus(1'b1, 7, 'hF, 32'hDEADBEEF, 1'b1, 7);
    @(negedge clk);
    check_output("collide_full_a", rd_rsp_data_a, BYPASS ? 32'hDEADBEEF : 32'h0);
    apply_stimulus(1'b1, 7, 'h3, 32'h12345678, 1'b1, 7);
    @(negedge clk);
    check_output("collide_part_a", rd_rsp_data_a, BYPASS ? 32'hDEAD5678 : 32'hDEADBEEF);
    check_output("collide_full_b", rd_rsp_data_b, BYPASS ? 32'hDEADBEEF : 32'h0);
    apply_idle();
    @(negedge clk);
    check_output("collide_part_b", rd_rsp_data_b, BYPASS ? 32'hDEAD5678 : 32'hDEADBEEF);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, i, 'hF, 32'h100 + i, 1'b0, 0);
      @(negedge clk);
    end
    apply_idle();
    repeat (3) @(negedge clk);
    rd_rsp_ready = 1'b0;
    apply_stimulus(1'b0, 0, 0, '0, 1'b1, 0);
    @(negedge clk);
    check_bit("bp_valid_a", rd_rsp_valid_a, 1'b1);
    check_bit("bp_ready_a", rd_req_ready_a, 1'b0);
    check_bit("bp_ready_b_open", rd_req_ready_b, 1'b1);
    apply_stimulus(1'b0, 0, 0, '0, 1'b1, 1);
    @(negedge clk);
    check_bit("bp_valid_b", rd_rsp_valid_b, 1'b1);
    check_bit("bp_ready_b", rd_req_ready_b, 1'b0);
    apply_stimulus(1'b1, 0, 'hF, 32'hBAD0BAD0, 1'b1, 2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      apply_idle();
      check_output("bp_hold_a", rd_rsp_data_a, 32'h100);
      check_output("bp_hold_b", rd_rsp_data_b, 32'h100);
      check_bit("bp_hold_valid_a", rd_rsp_valid_a, 1'b1);
      check_bit("bp_hold_valid_b", rd_rsp_valid_b, 1'b1);
      check_bit("bp_hold_ready_a", rd_req_ready_a, 1'b0);
      check_bit("bp_hold_ready_b", rd_req_ready_b, 1'b0);
    end
    rd_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("bp_drained_a", rd_rsp_valid_a, 1'b0);
    check_bit("bp_drained_b", rd_rsp_valid_b, 1'b0);
    check_output("bp_queue_a", exp_q_a.size(), '0);
    check_output("bp_queue_b", exp_q_b.size(), '0);

    for (int c = 0; c < 400; c++) begin
      int wa;
      wa = $urandom_range(SIZE - 1, 0);
      apply_stimulus(1'($urandom_range(1, 0)), wa, $urandom_range(15, 0), DATAW'($urandom),
                     1'($urandom_range(1, 0)),
                     ($urandom_range(3, 0) == 0) ? wa : $urandom_range(SIZE - 1, 0));
      rd_rsp_ready = ($urandom_range(3, 0) != 0);
      @(negedge clk);
    end
    apply_idle();
    rd_rsp_ready = 1'b1;
    for (int i = 0; i < 30 && (exp_q_a.size() != 0 || exp_q_b.size() != 0); i++) @(negedge clk);
    check_output("rand_queue_a", exp_q_a.size(), '0);
    check_output("rand_queue_b", exp_q_b.size(), '0);

    rd_rsp_ready = 1'b0;
    apply_stimulus(1'b0, 0, 0, '0, 1'b1, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    apply_idle();
    rd_rsp_ready = 1'b1;
    @(negedge clk);
    check_bit("run_rst_valid_a", rd_rsp_valid_a, 1'b0);
    check_bit("run_rst_valid_b", rd_rsp_valid_b, 1'b0);
    check_output("run_rst_data_b", rd_rsp_data_b, '0);
    check_bit("run_rst_done", init_done_a, 1'b0);
    check_bit("run_rst_ready", rd_req_ready_b, 1'b0);

    reset = 1'b0;
    apply_stimulus(1'b1, 5, 'hF, 32'hFFFFFFFF, 1'b0, 0);
    repeat (7) @(negedge clk);
    check_bit("midfill_done", init_done_b, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    fill_and_check("fill2");
    read_all();
    check_output("final_queue_a", exp_q_a.size(), '0);
    check_output("final_queue_b", exp_q_b.size(), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
